rom_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the microprocessor's program ROM (256 words x 9 bits, combinational read).
- Owns the program counter and drives the ROM address.
- Registers the returned word into a single-entry valid/ready output slot for the decoder.
- Handles jump, call and return redirects with a small hardware return stack, plus start/halt control.

---
 rtl/rom_fetch_ctrl_if.sv | 31 +++
 rtl/rom_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_rom_fetch_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_fetch_ctrl_if.sv
// Fetch-controller bus: ROM address/data, decoder instruction slot, redirect and run control.
// master = fetch controller, slave = ROM + decoder side.
interface rom_fetch_ctrl_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned IW = 9
);
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_data;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          jump;
  logic          call;
  logic          ret;
  logic [AW-1:0] jump_addr;
  logic          halt;
  logic          halted;
  logic          stack_err;

  modport master (
    input  start, rom_data, instr_ready, jump, call, ret, jump_addr, halt,
    output rom_addr, instr, instr_pc, instr_valid, halted, stack_err
  );

  modport slave (
    output start, rom_data, instr_ready, jump, call, ret, jump_addr, halt,
    input  rom_addr, instr, instr_pc, instr_valid, halted, stack_err
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// Program-ROM fetch sequencer: owns the PC, fills a one-entry instruction slot and applies
// jump/call/ret/halt redirects on accepted instructions using a small return stack.
module rom_fetch_ctrl #(
  parameter int unsigned   AW       = 8,
  parameter int unsigned   IW       = 9,
  parameter int unsigned   SD       = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             rst,
  rom_fetch_ctrl_if.master bus
);

  localparam int unsigned SPW  = $clog2(SD + 1);
  localparam int unsigned IDXW = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] instr_pc_q;
  logic [IW-1:0] instr_q;
  logic          valid_q;
  logic          halted_q;
  logic          err_q;
  logic [SPW-1:0] sp_q;
  logic [AW-1:0] stack_q [SD];

  logic           accept;
  logic           stack_empty;
  logic           stack_full;
  logic [SPW-1:0] sp_dec;
  logic [IDXW-1:0] top_idx;
  logic [IDXW-1:0] push_idx;
  logic [AW-1:0]  seq_pc;
  logic [AW-1:0]  link_pc;
  logic           do_halt;
  logic           do_ret;
  logic           ret_underflow;
  logic           do_call;
  logic           do_jump;
  logic           load;

  always_comb begin
    accept        = valid_q & bus.instr_ready;
    stack_empty   = (sp_q == '0);
    stack_full    = (sp_q == SPW'(SD));
    sp_dec        = sp_q - SPW'(1);
    top_idx       = sp_dec[IDXW-1:0];
    push_idx      = sp_q[IDXW-1:0];
    seq_pc        = pc_q + AW'(1);
    link_pc       = instr_pc_q + AW'(1);
    // Fixed priority halt > ret > call > jump; an empty-stack ret falls through to a plain load.
    do_halt       = accept & bus.halt;
    do_ret        = accept & ~bus.halt & bus.ret & ~stack_empty;
    ret_underflow = accept & ~bus.halt & bus.ret & stack_empty;
    do_call       = accept & ~bus.halt & ~bus.ret & bus.call;
    do_jump       = accept & ~bus.halt & ~bus.ret & ~bus.call & bus.jump;
    load          = (~valid_q | bus.instr_ready) & ~(do_halt | do_ret | do_call | do_jump);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      sp_q       <= '0;
      for (int unsigned i = 0; i < SD; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StFetch;
          end
        end

        StHalt: begin
          if (bus.start) begin
            state_q  <= StFetch;
            halted_q <= 1'b0;
          end
        end

        StFetch: begin
          if (do_halt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
            valid_q  <= 1'b0;
            pc_q     <= link_pc;
          end else if (do_ret) begin
            pc_q    <= stack_q[top_idx];
            sp_q    <= sp_dec;
            valid_q <= 1'b0;
          end else if (do_call) begin
            if (stack_full) begin
              err_q <= 1'b1;
            end else begin
              stack_q[push_idx] <= link_pc;
              sp_q              <= sp_q + SPW'(1);
            end
            pc_q    <= bus.jump_addr;
            valid_q <= 1'b0;
          end else if (do_jump) begin
            pc_q    <= bus.jump_addr;
            valid_q <= 1'b0;
          end else if (load) begin
            instr_q    <= bus.rom_data;
            instr_pc_q <= pc_q;
            valid_q    <= 1'b1;
            pc_q       <= seq_pc;
          end
          if (ret_underflow) begin
            err_q <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;
  assign bus.stack_err   = err_q;

  assert property (@(posedge clk) disable iff (rst) halted_q |-> !valid_q);
  assert property (@(posedge clk) disable iff (rst) sp_q <= SPW'(SD));

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Bench for rom_fetch_ctrl: a program-order reference model predicts each accepted word,
// and a negedge monitor pops and compares them, including the bubble count before each word.
module tb_rom_fetch_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 9;
  localparam int unsigned SD = 4;
  localparam logic [AW-1:0] RESET_PC = 8'h00;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rom_fetch_ctrl_if #(.AW(AW), .IW(IW)) bus ();

  rom_fetch_ctrl #(.AW(AW), .IW(IW), .SD(SD), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [IW-1:0] rom [256];
  assign bus.rom_data = rom[bus.rom_addr];

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] word;
    int            gap;   // invalid cycles expected before this word appears, -1 = unchecked
  } exp_t;

  typedef enum {MIdle, MRun, MHalt} mstate_e;

  exp_t          sb [$];
  exp_t          mon_e;
  mstate_e       m_state;
  logic [AW-1:0] m_cur;
  logic [AW-1:0] m_stack [$];
  bit            m_err;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int gap_cnt = 0;
  bit fresh = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_word(input logic [AW-1:0] a, input int gap);
    exp_t e;
    e.pc   = a;
    e.word = rom[a];
    e.gap  = gap;
    sb.push_back(e);
    m_cur = a;
  endtask

  // Drive one cycle, advance the model on an accept, then check run state after the edge.
  task automatic step(input bit rdy, input bit j, input bit c, input bit r, input bit h,
                      input bit s, input logic [AW-1:0] a);
    bit acc;
    bus.instr_ready = rdy;
    bus.jump        = j;
    bus.call        = c;
    bus.ret         = r;
    bus.halt        = h;
    bus.start       = s;
    bus.jump_addr   = a;
    acc = (bus.instr_valid === 1'b1) && rdy;
    if (m_state == MRun && acc) begin
      if (h) begin
        m_state = MHalt;
        m_cur   = AW'(m_cur + 1);
      end else if (r && m_stack.size() > 0) begin
        expect_word(m_stack.pop_back(), 1);
      end else if (r) begin
        m_err = 1'b1;
        expect_word(AW'(m_cur + 1), 0);
      end else if (c) begin
        if (m_stack.size() < SD) m_stack.push_back(AW'(m_cur + 1));
        else m_err = 1'b1;
        expect_word(a, 1);
      end else if (j) begin
        expect_word(a, 1);
      end else begin
        expect_word(AW'(m_cur + 1), 0);
      end
    end else if (m_state != MRun && s) begin
      m_state = MRun;
      expect_word(m_cur, -1);
    end
    @(posedge clk);
    #1;
    chk("halted", bus.halted, m_state == MHalt);
    chk("stack_err", bus.stack_err, m_err);
    if (m_state != MRun) chk("valid_when_stopped", bus.instr_valid, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic expect_presented(input string name, input logic [AW-1:0] pc);
    chk({name, "_valid"}, bus.instr_valid, 1);
    chk({name, "_pc"}, bus.instr_pc, pc);
    chk({name, "_instr"}, bus.instr, rom[pc]);
  endtask

  task automatic apply_reset();
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump        = 1'b0;
    bus.call        = 1'b0;
    bus.ret         = 1'b0;
    bus.halt        = 1'b0;
    bus.jump_addr   = '0;
    sb.delete();
    m_stack.delete();
    m_state = MIdle;
    m_cur   = RESET_PC;
    m_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: checks every accepted word against the scoreboard, and bubble length on arrival.
  always @(negedge clk) begin
    if (rst) begin
      fresh   = 1'b1;
      gap_cnt = 0;
    end else if (bus.instr_valid === 1'b1) begin
      if (fresh) begin
        if (sb.size() == 0) chk("unexpected_valid", 1, 0);
        else if (sb[0].gap >= 0) chk("bubble_gap", gap_cnt, sb[0].gap);
        fresh = 1'b0;
      end
      if (bus.instr_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("stream_pc", bus.instr_pc, mon_e.pc);
          chk("stream_instr", bus.instr, mon_e.word);
          pops++;
        end
        fresh   = 1'b1;
        gap_cnt = 0;
      end
    end else begin
      gap_cnt++;
    end
  end

  logic [AW-1:0] tgt;
  logic [AW-1:0] ret_exp [4];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = IW'($urandom_range(0, 511));
    rom[0] = 9'h101;
    rom[1] = 9'h102;
    rom[2] = 9'h103;
    rom[3] = 9'h104;

    // Reset state, start latency, first words.
    apply_reset();
    chk("reset_valid", bus.instr_valid, 0);
    chk("reset_rom_addr", bus.rom_addr, RESET_PC);
    chk("reset_halted", bus.halted, 0);
    chk("reset_stack_err", bus.stack_err, 0);
    step(1, 0, 0, 0, 0, 1, '0);
    chk("start_bubble", bus.instr_valid, 0);
    step(1, 0, 0, 0, 0, 0, '0);
    expect_presented("first", 8'h00);
    run(2);
    expect_presented("seq2", 8'h02);

    // Backpressure holds the slot and the PC.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, '0);
      expect_presented("stall", 8'h02);
      chk("stall_rom_addr", bus.rom_addr, 8'h03);
    end
    step(1, 0, 0, 0, 0, 0, '0);
    expect_presented("release", 8'h03);
    run(2);
    expect_presented("pre_jump", 8'h05);

    // Jump, call and return, each with one bubble.
    step(1, 1, 0, 0, 0, 0, 8'h40);
    chk("jump_bubble", bus.instr_valid, 0);
    step(1, 0, 0, 0, 0, 0, '0);
    expect_presented("jump_target", 8'h40);
    step(1, 1, 0, 0, 0, 0, 8'h10);
    run(1);
    expect_presented("pre_call", 8'h10);
    step(1, 0, 1, 0, 0, 0, 8'h80);
    chk("call_bubble", bus.instr_valid, 0);
    step(1, 0, 0, 0, 0, 0, '0);
    expect_presented("call_target", 8'h80);
    run(2);
    expect_presented("pre_ret", 8'h82);
    step(1, 0, 0, 1, 0, 0, '0);
    chk("ret_bubble", bus.instr_valid, 0);
    step(1, 0, 0, 0, 0, 0, '0);
    expect_presented("ret_target", 8'h11);

    // Five nested calls overflow a four-deep stack; five returns underflow once.
    apply_reset();
    step(1, 0, 0, 0, 0, 1, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      tgt = AW'(8'h20 + 8'h10 * i);
      step(1, 0, 1, 0, 0, 0, tgt);
      step(1, 0, 0, 0, 0, 0, '0);
      expect_presented("nested_target", tgt);
    end
    chk("overflow_err", bus.stack_err, 1);
    ret_exp[0] = 8'h41;
    ret_exp[1] = 8'h31;
    ret_exp[2] = 8'h21;
    ret_exp[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 1, 0, 0, '0);
      step(1, 0, 0, 0, 0, 0, '0);
      expect_presented("nested_ret", ret_exp[i]);
    end
    step(1, 0, 0, 1, 0, 0, '0);
    expect_presented("underflow_seq", 8'h02);
    run(3);
    chk("err_sticky", bus.stack_err, 1);

    // PC wrap at the top of the program space.
    step(1, 1, 0, 0, 0, 0, 8'hfe);
    run(1);
    expect_presented("wrap_fe", 8'hfe);
    run(1);
    expect_presented("wrap_ff", 8'hff);
    run(1);
    expect_presented("wrap_00", 8'h00);

    // Halt beats a simultaneous start; a later start resumes sequentially.
    step(1, 1, 0, 0, 0, 0, 8'h07);
    run(1);
    expect_presented("pre_halt", 8'h07);
    step(1, 0, 0, 0, 1, 1, '0);
    chk("halt_halted", bus.halted, 1);
    chk("halt_valid", bus.instr_valid, 0);
    run(3);
    step(1, 0, 0, 0, 0, 1, '0);
    step(1, 0, 0, 0, 0, 0, '0);
    expect_presented("resume", 8'h08);

    // Asynchronous reset between edges takes effect immediately.
    step(1, 0, 0, 0, 0, 0, '0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_valid", bus.instr_valid, 0);
    chk("async_rom_addr", bus.rom_addr, RESET_PC);
    chk("async_err", bus.stack_err, 0);
    apply_reset();

    // Randomized traffic against the model.
    pops = 0;
    step(1, 0, 0, 0, 0, 1, '0);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
           (m_state != MRun) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0),
           AW'($urandom_range(0, 255)));
    end
    chk("stream_progress", pops > 300, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
